ps2_tx: RTL and testbench
=========================

Name: ps2_tx

Overview:
- PS/2 host-to-device transmitter: the other direction of the existing PS/2 keyboard receiver.
- Sits as a Wishbone slave on a free conbus slave port (s4). CPU writes a command byte (e.g. 0xED set-LEDs, 0xFF reset); the block runs the PS/2 host request-to-send sequence and reports completion/error status.
- Drives the shared PS2_clk/PS2_Data lines through open-drain enables.
- Asserts rx_inhibit so the receiver ignores its own transmitted frame.

Parameters:
- INHIBIT_CYCLES, 5000, clocks the host holds PS2_clk low before start (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000, max clocks between device clock falling edges before abort (20 ms).
- FILTER_LEN, 8, consecutive equal samples needed to accept a PS2_clk level change.

Ports:
- clk  in  1  block clock (clkdiv[0], 50 MHz)
- rst  in  1  reset, asynchronous, active-low
- dat_i  in  32  Wishbone write data
- adr_i  in  32  Wishbone address; only adr_i[2] decoded
- we_i  in  1  Wishbone write enable
- stb_i  in  1  Wishbone strobe
- dat_o  out  32  Wishbone read data
- ack_o  out  1  Wishbone acknowledge
- PS2_clk  in  1  PS/2 clock line level (async)
- PS2_Data  in  1  PS/2 data line level (async)
- ps2_clk_oe  out  1  1 = pull PS2_clk low
- ps2_data_oe  out  1  1 = pull PS2_Data low
- rx_inhibit  out  1  high while a transmission is active
- tx_done  out  1  one-clock pulse on successful completion

Behaviour:
- Reset (rst=0, async): state IDLE; ps2_clk_oe=0, ps2_data_oe=0, ack_o=0, dat_o=0, rx_inhibit=0, tx_done=0; all status flags 0. Lines are released immediately, including mid-frame.
- Input conditioning: PS2_clk and PS2_Data pass through 2-FF synchronisers. PS2_clk is then filtered (level accepted after FILTER_LEN equal samples). A falling edge (fe) is a filtered 1->0 transition.
- Wishbone access:
  - ack_o=1 in the cycle after stb_i=1 with ack_o=0, then 0 for one cycle. Single-cycle ack; no wait states.
  - Write, adr_i[2]=0 (TXDATA): if IDLE, latch dat_i[7:0], clear done/nack/timeout, start. If busy, ignore data and set ovr.
  - Write, adr_i[2]=1 (CTRL): dat_i[0]=1 clears all sticky flags.
  - Read (any adr): dat_o={27'b0, ovr, timeout, nack, done, busy}, registered with ack_o.
- Parity: odd parity = ~^data.
- State machine:
  - IDLE: no transmission in progress.
  - INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES clocks. On the last cycle set ps2_data_oe=1 (start bit).
  - REQ: ps2_clk_oe=0, ps2_data_oe=1; wait for fe.
  - DATA: drive the bit after each fe, with ps2_data_oe = ~bit. fe1..fe8 drive data bits 0..7 (LSB first). fe9 drives parity.
  - STOP: on fe10, ps2_data_oe=0 (stop bit 1).
  - ACK: on fe11, sample synced PS2_Data. 0 means success; 1 sets nack.
  - WAIT_IDLE: wait until filtered PS2_clk=1 and PS2_Data=1, then go to IDLE. On success, pulse tx_done and set the done flag on entry to IDLE.
- busy=1 and rx_inhibit=1 in every state except IDLE.
- Bit counter: 4 bits, counts fe 0..11; cleared on entering INHIBIT.
- Timeout:
  - Counter is cleared on entering REQ and on every fe.
  - If it reaches TIMEOUT_CYCLES in REQ, DATA, STOP, ACK or WAIT_IDLE: release both lines the same cycle, set timeout, go to IDLE, no tx_done.
- Simultaneous events: a CTRL clear in the same cycle as a flag set gives priority to the set. A TXDATA write in the same cycle as the return to IDLE is treated as busy (ignored, ovr set).

Decomposition:
- Shared package ps2_pkg: state encoding constants, register offsets (TXDATA=0, CTRL=4), status bit indices. The existing receiver uses the same package.
- One natural sub-module: ps2_line_filter (synchroniser + glitch filter + falling-edge pulse, parameter FILTER_LEN). The receiver can reuse it.

Test Plan (bench uses INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000, FILTER_LEN=2, device model clocking at 40-clock half-period):
- Write 0xED -> PS2_clk held low exactly 20 clocks, start bit 0; device samples 1,0,1,1,0,1,1,1, parity 1, stop 1. Model acks with 0 -> tx_done pulse, status read = 0x02.
- Write 0x00 -> data bits all 0, parity 1. Model leaves data high at fe11 -> status = 0x04 (nack), no tx_done.
- Write 0xFF with a silent device (never clocks) -> both oe low ~2000 clocks after REQ entry; status = 0x08; rx_inhibit drops.
- Write 0xF4 then 0x12 while busy -> 0xF4 frame transmitted unchanged; status bit4 (ovr) = 1. CTRL write 0x1 -> status = 0x00.
- Assert rst low after fe5 -> ps2_clk_oe=ps2_data_oe=0 combinationally; after release, status = 0x00; a new write of 0xED completes normally.
- 1-clock glitch on PS2_clk during DATA -> no extra bit counted; frame still 0xED-correct.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM encoding, register map, status bit positions.
// Used by both the host transmitter and the keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_DATA      = 3'd3,
    ST_STOP      = 3'd4,
    ST_ACK       = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } ps2_state_e;

  localparam logic [31:0] REG_TXDATA = 32'h0000_0000;
  localparam logic [31:0] REG_CTRL   = 32'h0000_0004;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_NACK = 2;
  localparam int STAT_TMO  = 3;
  localparam int STAT_OVR  = 4;

  // Falling-edge count at which the parity bit is on the line.
  localparam logic [3:0] FE_PARITY = 4'd9;
  localparam logic [3:0] FE_MAX    = 4'd11;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// Wishbone slave port bundle for the PS/2 transmitter.
// Handshake: a request is stb_i=1 while ack_o=0; ack_o answers for exactly one
// cycle on the next clock, write data/address are taken in the request cycle.
interface ps2_tx_if;
  logic [31:0] dat_i;
  logic [31:0] adr_i;
  logic        we_i;
  logic        stb_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport master (
    output dat_i, adr_i, we_i, stb_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  dat_i, adr_i, we_i, stb_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Synchroniser plus glitch filter for an async PS/2 line, with a one-clock
// pulse on each accepted high-to-low transition.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic fe
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    // A new level is accepted only after FILTER_LEN consecutive samples
    // disagree with the current one; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            level  <= 1'b1;
            fe     <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            fe     <= 1'b0;
            if (sync_q[1] == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level <= sync_q[1];
                fe    <= level;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter behind a Wishbone slave port: runs the
// request-to-send sequence, shifts out one command byte and reports status.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    ps2_tx_if.slave    wb,
    input  logic       PS2_clk,
    input  logic       PS2_Data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       rx_inhibit,
    output logic       tx_done,
    output ps2_state_e state_dbg
);

    localparam int TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW      = $clog2(TMR_MAX + 1);

    ps2_state_e    state_q, state_d;
    logic [TW-1:0] timer_q;
    logic [3:0]    bit_cnt_q;
    logic [7:0]    tx_byte_q;
    logic          ack_ok_q;
    logic          done_q, nack_q, tmo_q, ovr_q;
    logic          ack_q;
    logic [31:0]   dat_q;
    logic          tx_done_q;
    logic [1:0]    data_sync_q;

    logic clk_level, fe, data_sync;
    logic wb_acc, wr_tx, wr_ctrl, rd, clr;
    logic busy, start, inh_last, tmo_armed, tmo_hit, lines_idle, ack_fe, finish_ok;
    logic [8:0]  frame;
    logic [3:0]  bit_idx;
    logic        frame_bit;
    logic [31:0] status;
    logic        unused_wb;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .rst_n (rst),
        .din   (PS2_clk),
        .level (clk_level),
        .fe    (fe)
    );

    // The data line only needs synchronising; it is sampled on filtered edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) data_sync_q <= 2'b11;
        else      data_sync_q <= {data_sync_q[0], PS2_Data};
    end
    assign data_sync = data_sync_q[1];

    assign wb_acc  = wb.stb_i && !wb.ack_o;
    assign wr_tx   = wb_acc && wb.we_i && (wb.adr_i[2] == REG_TXDATA[2]);
    assign wr_ctrl = wb_acc && wb.we_i && (wb.adr_i[2] == REG_CTRL[2]);
    assign rd      = wb_acc && !wb.we_i;
    assign clr     = wr_ctrl && wb.dat_i[0];
    assign unused_wb = ^{wb.adr_i[31:3], wb.adr_i[1:0], wb.dat_i[31:8]};

    assign busy       = (state_q != ST_IDLE);
    assign start      = wr_tx && !busy;
    assign inh_last   = (state_q == ST_INHIBIT) && (timer_q == TW'(INHIBIT_CYCLES - 1));
    assign tmo_armed  = state_q inside {ST_REQ, ST_DATA, ST_STOP, ST_ACK, ST_WAIT_IDLE};
    assign tmo_hit    = tmo_armed && (timer_q == TW'(TIMEOUT_CYCLES));
    assign lines_idle = clk_level && data_sync;
    assign ack_fe     = (state_q == ST_ACK) && fe && !tmo_hit;
    assign finish_ok  = (state_q == ST_WAIT_IDLE) && lines_idle && ack_ok_q && !tmo_hit;

    // fe k puts frame bit k-1 on the line: data LSB first, then parity.
    assign frame     = {odd_parity(tx_byte_q), tx_byte_q};
    assign bit_idx   = bit_cnt_q - 4'd1;
    assign frame_bit = (bit_idx < 4'd9) ? frame[bit_idx] : 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; a timeout overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (start)                          state_d = ST_INHIBIT;
            ST_INHIBIT:   if (inh_last)                       state_d = ST_REQ;
            ST_REQ:       if (fe)                             state_d = ST_DATA;
            ST_DATA:      if (fe && (bit_cnt_q == FE_PARITY)) state_d = ST_STOP;
            ST_STOP:      if (clk_level)                      state_d = ST_ACK;
            ST_ACK:       if (fe)                             state_d = ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (lines_idle)                     state_d = ST_IDLE;
            default:                                          state_d = ST_IDLE;
        endcase
        if (tmo_hit) state_d = ST_IDLE;
    end

    // Line drive; outputs decode from the async-reset state so reset frees the bus at once.
    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        unique case (state_q)
            ST_INHIBIT: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = inh_last;
            end
            ST_REQ:  ps2_data_oe = 1'b1;
            ST_DATA: ps2_data_oe = ~frame_bit;
            default: ;
        endcase
        if (tmo_hit) begin
            ps2_clk_oe  = 1'b0;
            ps2_data_oe = 1'b0;
        end
    end

    assign rx_inhibit = busy;
    assign state_dbg  = state_q;

    // Shared timer: inhibit length in INHIBIT, gap between device edges afterwards.
    // Edges during INHIBIT come from our own clock pull and are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q   <= '0;
            bit_cnt_q <= '0;
            tx_byte_q <= '0;
            ack_ok_q  <= 1'b0;
        end else begin
            if (start || inh_last || (fe && tmo_armed)) timer_q <= '0;
            else if (busy)                              timer_q <= timer_q + TW'(1);

            if (start)                                             bit_cnt_q <= '0;
            else if (fe && tmo_armed && (bit_cnt_q != FE_MAX))     bit_cnt_q <= bit_cnt_q + 4'd1;

            if (start) tx_byte_q <= wb.dat_i[7:0];

            if (start)       ack_ok_q <= 1'b0;
            else if (ack_fe) ack_ok_q <= ~data_sync;
        end
    end

    // Sticky flags: a set in the same cycle as a CTRL clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q    <= 1'b0;
            nack_q    <= 1'b0;
            tmo_q     <= 1'b0;
            ovr_q     <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= finish_ok;

            if (finish_ok)         done_q <= 1'b1;
            else if (start || clr) done_q <= 1'b0;

            if (ack_fe && data_sync) nack_q <= 1'b1;
            else if (start || clr)   nack_q <= 1'b0;

            if (tmo_hit)           tmo_q <= 1'b1;
            else if (start || clr) tmo_q <= 1'b0;

            if (wr_tx && busy) ovr_q <= 1'b1;
            else if (clr)      ovr_q <= 1'b0;
        end
    end

    assign tx_done = tx_done_q;

    always_comb begin
        status            = '0;
        status[STAT_BUSY] = busy;
        status[STAT_DONE] = done_q;
        status[STAT_NACK] = nack_q;
        status[STAT_TMO]  = tmo_q;
        status[STAT_OVR]  = ovr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= wb_acc;
            dat_q <= rd ? status : 32'd0;
        end
    end

    assign wb.ack_o = ack_q;
    assign wb.dat_o = dat_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a behavioural PS/2 device clocks frames out of the host;
// expected frames are queued at write time and checked as the device receives them.
module tb_ps2_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int TMO  = 2000;
  localparam int FLT  = 2;
  localparam int HALF = 40;

  logic       clk, rst;
  logic       PS2_clk, PS2_Data;
  logic       ps2_clk_oe, ps2_data_oe, rx_inhibit, tx_done;
  ps2_state_e state_dbg;
  logic       dev_clk, dev_data, glitch;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [9:0] exp_q[$];

  ps2_tx_if wb();

  // Open-drain lines: either side can pull low.
  assign PS2_clk  = dev_clk & ~ps2_clk_oe & ~glitch;
  assign PS2_Data = dev_data & ~ps2_data_oe;

  ps2_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN(FLT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wb(wb),
    .PS2_clk(PS2_clk),
    .PS2_Data(PS2_Data),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .rx_inhibit(rx_inhibit),
    .tx_done(tx_done),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (tx_done === 1'b1) done_cnt++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

  // ---------------- drivers ----------------
  task automatic wb_write(input logic [31:0] adr, input logic [31:0] d);
    @(negedge clk);
    wb.stb_i = 1'b1; wb.we_i = 1'b1; wb.adr_i = adr; wb.dat_i = d;
    @(negedge clk);
    wb.stb_i = 1'b0; wb.we_i = 1'b0;
  endtask

  task automatic wb_read(output logic [31:0] d);
    @(negedge clk);
    wb.stb_i = 1'b1; wb.we_i = 1'b0; wb.adr_i = REG_TXDATA;
    @(negedge clk);
    d = (wb.ack_o === 1'b1) ? wb.dat_o : 32'hDEAD_BEEF;
    wb.stb_i = 1'b0;
  endtask

  // Device side of one host-to-device frame: measure the inhibit, then clock
  // 10 bits (sampled at each rising edge) and answer the 11th clock with ack.
  task automatic device_frame(input bit do_ack, input bit do_glitch,
                              output logic [9:0] got, output int inh_len,
                              output bit start_ok);
    int n;
    n = 0; inh_len = 0; got = '0;
    while (n < 500) begin
      @(negedge clk); n++;
      if (ps2_clk_oe) inh_len++;
      else if (inh_len > 0) break;
    end
    start_ok = (inh_len > 0) && !ps2_clk_oe && (PS2_Data === 1'b0);
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      got[k] = PS2_Data;
      if (do_glitch && k == 3) begin
        repeat (HALF / 2) @(negedge clk);
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        repeat (HALF - HALF / 2 - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    if (do_ack) dev_data = 1'b0;
    repeat (5) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (10) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] b, input bit do_ack, input bit do_glitch,
                           output logic [9:0] got, output int inh_len, output bit start_ok);
    exp_q.push_back(frame_of(b));
    fork
      wb_write(REG_TXDATA, {24'h0, b});
      device_frame(do_ack, do_glitch, got, inh_len, start_ok);
    join
    repeat (20) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] st;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, rx_inhibit, tx_done, wb.ack_o} !== 5'b0 || wb.dat_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got oe=%b%b inh=%b done=%b ack=%b dat=%h want all zero",
               ps2_clk_oe, ps2_data_oe, rx_inhibit, tx_done, wb.ack_o, wb.dat_o);
    end
    checks++;
    if (state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", state_dbg, ST_IDLE);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    wb_read(st);
    checks++;
    if (st !== 32'h0) begin
      errors++;
      $display("FAIL reset_status: got %h want %h", st, 32'h0);
    end
  endtask

  task automatic test_wb_ack();
    logic [2:0] pat;
    logic [2:0] exp_pat;
    exp_pat = 3'b101;
    @(negedge clk);
    wb.stb_i = 1'b1; wb.we_i = 1'b0; wb.adr_i = REG_CTRL;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pat[i] = wb.ack_o;
    end
    wb.stb_i = 1'b0;
    @(negedge clk);
    checks++;
    if (pat !== exp_pat) begin
      errors++;
      $display("FAIL wb_ack_pattern: got %b want %b", pat, exp_pat);
    end
  endtask

  task automatic test_ack_frame(input logic [7:0] b, input bit do_glitch, input string name);
    logic [9:0]  got, exp;
    logic [31:0] st;
    int inh, d0;
    bit sok;
    d0 = done_cnt;
    run_frame(b, 1'b1, do_glitch, got, inh, sok);
    checks++;
    if (inh !== INH) begin
      errors++;
      $display("FAIL %s_inhibit_len: got %0d want %0d", name, inh, INH);
    end
    checks++;
    if (!sok) begin
      errors++;
      $display("FAIL %s_start_bit: got line not low after inhibit want start bit 0", name);
    end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s_frame: got %b want %b", name, got, exp);
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL %s_tx_done: got %0d pulses want 1", name, done_cnt - d0);
    end
    wb_read(st);
    checks++;
    if (st !== 32'h02) begin
      errors++;
      $display("FAIL %s_status: got %h want %h", name, st, 32'h02);
    end
  endtask

  task automatic test_nack();
    logic [9:0]  got, exp;
    logic [31:0] st;
    int inh, d0;
    bit sok;
    d0 = done_cnt;
    run_frame(8'h00, 1'b0, 1'b0, got, inh, sok);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL nack_frame: got %b want %b", got, exp);
    end
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL nack_tx_done: got %0d pulses want 0", done_cnt - d0);
    end
    wb_read(st);
    checks++;
    if (st !== 32'h04) begin
      errors++;
      $display("FAIL nack_status: got %h want %h", st, 32'h04);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] st;
    int n, inh, cnt, d0;
    d0 = done_cnt;
    wb_write(REG_TXDATA, 32'h0000_00FF);
    n = 0; inh = 1;
    while (n < 500 && ps2_clk_oe) begin
      @(negedge clk); n++;
    end
    cnt = 0;
    while (ps2_data_oe && cnt < 3000) begin
      @(negedge clk); cnt++;
    end
    checks++;
    if (cnt < TMO - 5 || cnt > TMO + 5 || ps2_clk_oe !== 1'b0) begin
      errors++;
      $display("FAIL timeout_release: got %0d cycles clk_oe=%b want ~%0d cycles clk_oe=0",
               cnt, ps2_clk_oe, TMO);
    end
    @(negedge clk);
    checks++;
    if (rx_inhibit !== 1'b0) begin
      errors++;
      $display("FAIL timeout_rx_inhibit: got %b want 0", rx_inhibit);
    end
    wb_read(st);
    checks++;
    if (st !== 32'h08 || done_cnt !== d0) begin
      errors++;
      $display("FAIL timeout_status: got %h pulses %0d want %h pulses 0", st, done_cnt - d0, 32'h08);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  got, exp;
    logic [31:0] st_mid, st;
    int inh;
    bit sok;
    exp_q.push_back(frame_of(8'hF4));
    fork
      wb_write(REG_TXDATA, 32'h0000_00F4);
      device_frame(1'b1, 1'b0, got, inh, sok);
      begin
        repeat (200) @(negedge clk);
        wb_write(REG_TXDATA, 32'h0000_0012);
        wb_read(st_mid);
      end
    join
    repeat (20) @(negedge clk);
    checks++;
    if (st_mid !== 32'h11) begin
      errors++;
      $display("FAIL b2b_status_busy: got %h want %h", st_mid, 32'h11);
    end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL b2b_frame: got %b want %b", got, exp);
    end
    wb_read(st);
    checks++;
    if (st !== 32'h12) begin
      errors++;
      $display("FAIL b2b_status_ovr: got %h want %h", st, 32'h12);
    end
    wb_write(REG_CTRL, 32'h1);
    wb_read(st);
    checks++;
    if (st !== 32'h0) begin
      errors++;
      $display("FAIL ctrl_clear: got %h want %h", st, 32'h0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] st;
    int n, inh;
    fork
      wb_write(REG_TXDATA, 32'h0000_00ED);
      begin
        n = 0; inh = 0;
        while (n < 500) begin
          @(negedge clk); n++;
          if (ps2_clk_oe) inh++;
          else if (inh > 0) break;
        end
      end
    join
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_clk = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (ps2_data_oe !== 1'b1 || state_dbg !== ST_DATA) begin
      errors++;
      $display("FAIL midframe_bit4: got data_oe=%b state=%0d want data_oe=1 state=%0d",
               ps2_data_oe, state_dbg, ST_DATA);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, rx_inhibit} !== 3'b000) begin
      errors++;
      $display("FAIL midframe_reset_release: got clk_oe=%b data_oe=%b inh=%b want 000",
               ps2_clk_oe, ps2_data_oe, rx_inhibit);
    end
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    wb_read(st);
    checks++;
    if (st !== 32'h0) begin
      errors++;
      $display("FAIL midframe_status: got %h want %h", st, 32'h0);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b0;
    dev_clk = 1'b1; dev_data = 1'b1; glitch = 1'b0;
    wb.stb_i = 1'b0; wb.we_i = 1'b0; wb.adr_i = '0; wb.dat_i = '0;

    test_reset();
    test_wb_ack();
    test_ack_frame(8'hED, 1'b0, "ed");
    test_nack();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    test_ack_frame(8'hED, 1'b0, "after_reset");
    test_ack_frame(8'hED, 1'b1, "glitch");
    test_ack_frame(8'($urandom_range(0, 255)), 1'b0, "random");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d frames left want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
